// File: rtl/mode_pkg.sv
// Shared types and default timing for the mode sequencer and its press classifier.
// Defaults assume a 50 MHz system clock.
package mode_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } press_state_e;

    typedef enum logic {
        ON  = 1'b0,
        OFF = 1'b1
    } blink_phase_e;

    localparam int unsigned DEF_BLINK_HALF  = 12_500_000;
    localparam int unsigned DEF_LONG_CYCLES = 100_000_000;

endpackage

// File: rtl/press_classifier.sv
// Classifies each button press as short or long, emitting exactly one event per press.
// Events are combinational and valid on the edge that classifies the press.
module press_classifier
    import mode_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic short_evt,
    output logic long_evt
);

    localparam int unsigned HW = $clog2(LONG_CYCLES);

    press_state_e  state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        short_evt  = 1'b0;
        long_evt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn) begin
                    state_d    = PRESSED;
                    hold_cnt_d = HW'(1);
                end
            end
            PRESSED: begin
                if (!btn) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    short_evt  = 1'b1;
                end else if (hold_cnt_q == HW'(LONG_CYCLES - 1)) begin
                    // Long is decided while still held; the later release is silent.
                    state_d    = HELD;
                    hold_cnt_d = '0;
                    long_evt   = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            HELD: begin
                if (!btn) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/mode_sequencer.sv
// Steps through N_MODES modes from one debounced button and drives a blinking,
// active-low one-hot mode indicator.
module mode_sequencer
    import mode_pkg::*;
#(
    parameter int unsigned N_MODES     = 4,
    parameter int unsigned BLINK_HALF  = DEF_BLINK_HALF,
    parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        btn,
    input  logic                        lock,
    output logic [$clog2(N_MODES)-1:0]  mode,
    output logic                        mode_changed,
    output logic                        long_press,
    output logic [N_MODES-1:0]          led_mode
);

    localparam int unsigned MW = $clog2(N_MODES);
    localparam int unsigned BW = $clog2(BLINK_HALF + 1);

    logic short_evt, long_evt;

    logic [MW-1:0]      mode_q, mode_d;
    logic               changed_q, changed_d;
    logic               long_q, long_d;
    logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
    blink_phase_e       phase_q, phase_d;
    logic [N_MODES-1:0] led_q, led_d;

    press_classifier #(
        .LONG_CYCLES(LONG_CYCLES)
    ) u_press (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .short_evt(short_evt),
        .long_evt (long_evt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q      <= '0;
            changed_q   <= 1'b0;
            long_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= ON;
            led_q       <= '1;
        end else begin
            mode_q      <= mode_d;
            changed_q   <= changed_d;
            long_q      <= long_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
        end
    end

    always_comb begin
        mode_d      = mode_q;
        changed_d   = 1'b0;
        long_d      = 1'b0;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        if (long_evt) begin
            long_d    = 1'b1;
            mode_d    = '0;
            changed_d = (mode_q != '0);
        end else if (short_evt && !lock) begin
            mode_d    = (mode_q == MW'(N_MODES - 1)) ? '0 : mode_q + MW'(1);
            changed_d = 1'b1;
        end

        // A mode change restarts the ON half so the new indicator is seen at once.
        if (changed_d) begin
            blink_cnt_d = '0;
            phase_d     = ON;
        end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            phase_d     = (phase_q == ON) ? OFF : ON;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end

        led_d = (phase_q == ON) ? ~(N_MODES'(1) << mode_q) : '1;
    end

    assign mode         = mode_q;
    assign mode_changed = changed_q;
    assign long_press   = long_q;
    assign led_mode     = led_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Randomised and directed bench for mode_sequencer against a press-length based reference model.
module tb_mode_sequencer;

    localparam int N_MODES     = 3;
    localparam int BLINK_HALF  = 4;
    localparam int LONG_CYCLES = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn = 1'b0;
    logic       lock = 1'b0;
    logic [1:0] mode;
    logic       mode_changed;
    logic       long_press;
    logic [2:0] led_mode;

    int totalCount = 0;
    int badCount   = 0;

    int       mPressLen = 0;
    bit       mLongDone = 0;
    int       mMode     = 0;
    int       mAge      = 0;
    bit       mChg      = 0;
    bit       mLp       = 0;
    logic [2:0] mLed    = 3'b111;

    mode_sequencer #(
        .N_MODES    (N_MODES),
        .BLINK_HALF (BLINK_HALF),
        .LONG_CYCLES(LONG_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .lock        (lock),
        .mode        (mode),
        .mode_changed(mode_changed),
        .long_press  (long_press),
        .led_mode    (led_mode)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: counts high samples per press and derives blink phase from age since restart.
    task automatic modelStep();
        bit shortE;
        bit longE;
        logic [2:0] ledNext;
        if (!rst) begin
            mPressLen = 0;
            mLongDone = 0;
            mMode     = 0;
            mAge      = 0;
            mChg      = 0;
            mLp       = 0;
            mLed      = 3'b111;
        end else begin
            ledNext = (((mAge / BLINK_HALF) % 2) == 0) ? ~(3'b001 << mMode) : 3'b111;
            shortE = 0;
            longE  = 0;
            if (btn) begin
                mPressLen++;
                if (mPressLen == LONG_CYCLES && !mLongDone) begin
                    longE     = 1;
                    mLongDone = 1;
                end
            end else begin
                if (mPressLen > 0 && !mLongDone) shortE = 1;
                mPressLen = 0;
                mLongDone = 0;
            end
            mChg = 0;
            mLp  = 0;
            if (longE) begin
                mLp   = 1;
                mChg  = (mMode != 0);
                mMode = 0;
            end else if (shortE && !lock) begin
                mMode = (mMode + 1) % N_MODES;
                mChg  = 1;
            end
            if (mChg) mAge = 0;
            else      mAge++;
            mLed = ledNext;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit b, input bit l);
        rst  = r;
        btn  = b;
        lock = l;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("mode", 32'(mode), 32'(mMode));
        checkOutput("mode_changed", 32'(mode_changed), 32'(mChg));
        checkOutput("long_press", 32'(long_press), 32'(mLp));
        checkOutput("led_mode", 32'(led_mode), 32'(mLed));
    endtask

    task automatic pressFor(input int highCycles, input int lowCycles, input bit l);
        for (int i = 0; i < highCycles; i++) applyStimulus(1'b1, 1'b1, l);
        for (int i = 0; i < lowCycles; i++) applyStimulus(1'b1, 1'b0, l);
    endtask

    initial begin
        int runLeft;
        bit btnLevel;

        @(negedge clk);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("reset mode", 32'(mode), 32'd0);
        checkOutput("reset led", 32'(led_mode), 32'b111);
        rst = 1'b1;
        btn = 1'b0;
        #1;
        checkOutput("release led", 32'(led_mode), 32'b111);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("first led", 32'(led_mode), 32'b110);

        pressFor(3, 2, 0);
        checkOutput("wrap 1", 32'(mode), 32'd1);
        pressFor(3, 2, 0);
        checkOutput("wrap 2", 32'(mode), 32'd2);
        pressFor(3, 2, 0);
        checkOutput("wrap 0", 32'(mode), 32'd0);
        pressFor(3, 2, 0);
        checkOutput("wrap 1b", 32'(mode), 32'd1);

        pressFor(3, 2, 1);
        checkOutput("lock hold", 32'(mode), 32'd1);
        pressFor(3, 2, 0);
        pressFor(12, 3, 1);
        checkOutput("long under lock", 32'(mode), 32'd0);

        pressFor(9, 2, 0);
        checkOutput("nine short", 32'(mode), 32'd1);
        pressFor(10, 3, 0);
        checkOutput("ten long", 32'(mode), 32'd0);
        pressFor(10, 3, 0);
        checkOutput("long from 0", 32'(mode), 32'd0);

        pressFor(2, 16, 0);
        pressFor(1, 10, 0);
        checkOutput("blink press", 32'(mode), 32'd2);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pressFor(0, 4, 0);
        checkOutput("reset mid press", 32'(mode), 32'd0);

        btnLevel = 0;
        runLeft  = 0;
        for (int i = 0; i < 1200; i++) begin
            if (runLeft == 0) begin
                btnLevel = ~btnLevel;
                runLeft  = btnLevel ? int'($urandom_range(1, 13)) : int'($urandom_range(1, 9));
            end
            runLeft--;
            applyStimulus(($urandom_range(0, 60) != 0), btnLevel, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Parametrised successor to the two-mode toggle-and-blink logic in the board top level.
- Manages N operating modes selected from one debounced button.
- Short press advances the mode with wrap-around. Long press forces mode 0. A lock input freezes short-press changes.
- Drives an active-low, one-hot, blinking mode-indicator bank. Sits between the button debouncer and the controller's mode input.

Parameters:
- N_MODES, 4: number of modes; must be >= 2. MW = clog2(N_MODES) is a derived localparam.
- BLINK_HALF, 12500000: clock cycles per blink half-period (0.25 s at 50 MHz); must be >= 1.
- LONG_CYCLES, 100000000: cycles the button must be held to classify a press as long; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- btn  in  1  debounced button level; 1 = pressed
- lock  in  1  1 = ignore short presses
- mode  out  MW  current mode, 0..N_MODES-1
- mode_changed  out  1  one-cycle pulse when mode takes a new value
- long_press  out  1  one-cycle pulse when a long press is classified
- led_mode  out  N_MODES  indicator, active-low; bit i is for mode i

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, hold_cnt=0, mode=0, mode_changed=0, long_press=0, blink_cnt=0, phase=ON, led_mode=all ones. rst overrides all other inputs, including a press in progress.
- Press FSM, one transition per edge:
  - IDLE, btn=1 -> PRESSED, hold_cnt=1.
  - PRESSED, btn=0 -> IDLE, short event this edge.
  - PRESSED, btn=1, hold_cnt==LONG_CYCLES-1 -> HELD, long event this edge. Otherwise hold_cnt+1.
  - HELD, btn=0 -> IDLE, no event. HELD, btn=1 -> stay.
- Press classification:
  - Short press = released after 1..LONG_CYCLES-1 sampled-high cycles.
  - A press of exactly LONG_CYCLES high cycles is long.
  - Exactly one event per press; the release after a long press produces nothing.
- Mode update, on the same edge as the event:
  - Short event and lock=0: mode = (mode==N_MODES-1) ? 0 : mode+1; mode_changed=1.
  - Short event and lock=1: no change, mode_changed=0.
  - Long event: long_press=1 and mode=0, regardless of lock. mode_changed=1 only if the previous mode was != 0.
  - mode_changed and long_press are 0 in every other cycle.
- Blink:
  - blink_cnt counts 0..BLINK_HALF-1; phase toggles on wrap.
  - On any edge where mode_changed is set, blink_cnt=0 and phase=ON. This restarts the ON half-period.
- led_mode is registered from the post-update mode and phase: ~(1<<mode) when ON, all ones when OFF.
  - Latency: led_mode lags mode by one cycle.
  - The first cycle after reset release shows all ones; the next edge shows bit0 low.
- Width rules: mode is never >= N_MODES. hold_cnt width is clog2(LONG_CYCLES) and never exceeds LONG_CYCLES-1. blink_cnt width is clog2(BLINK_HALF+1).
- btn held high through reset release counts as a new press starting in the first post-reset cycle.

Decomposition:
- Shared package mode_pkg holds:
  - FSM state encoding: IDLE=2'd0, PRESSED=2'd1, HELD=2'd2.
  - Blink phase constants ON/OFF.
  - Default timing constants for 50 MHz.
- One sub-module: press_classifier, containing the FSM and hold_cnt.
  - Inputs: clk, rst, btn.
  - Outputs: short_evt and long_evt, one-cycle pulses.
- Mode register, blink counter and LED register live in mode_sequencer.

Test Plan:
All scenarios use N_MODES=3, BLINK_HALF=4, LONG_CYCLES=10.
- Reset: rst=0 for 3 cycles, btn=1 -> mode=0, led_mode=3'b111, no pulses. Release rst -> led_mode=3'b110 one cycle later.
- Wrap: four short presses of 3 cycles each, lock=0 -> mode 1,2,0,1. mode_changed pulses once per press, on the release edge.
- Lock: lock=1, short press -> mode unchanged, mode_changed=0. Then a long press of 12 cycles from mode 2 -> long_press at the 10th high cycle, mode=0, mode_changed=1.
- Boundary: press held 9 cycles -> short (mode+1). Press held exactly 10 cycles -> long (mode=0). The release after the 10-cycle press produces no event.
- Long press from mode 0 -> long_press=1, mode_changed=0, blink not restarted.
- Blink: idle in mode 1 -> led_mode alternates 3'b101 x4 cycles, 3'b111 x4 cycles. A short press mid-OFF -> next led_mode=3'b011 held 4 cycles. Asserting rst mid-press returns state to IDLE with no event emitted.
